denise_sprite_sequencer: RTL and testbench

Controller for the eight Denise sprite shifter instances. Decodes chip-register writes into per-sprite address-enable/register-select strobes. Generates the shared pixel shift strobe from the sprite resolution setting. Arbitrates the eight serialized 2-bit sprite outputs by fixed priority, with attach handling, into one registered sprite pixel for the playfield/sprite priority logic.

---
 rtl/denise_sprite_sequencer.sv | 149 ++++++++++++++
 tb/tb_denise_sprite_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/denise_sprite_sequencer.sv
// rtl/denise_sprite_sequencer.sv - sprite register write decode, shift strobe and pixel priority for Denise.
// Optional macro SPR_SHRES_EN enables the super-hires (shift every clk) sprite resolution.
module denise_sprite_sequencer #(
  parameter logic [7:0] SPR_BASE = 8'hA0,
  parameter int         NSPR     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        reg_wr,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] data_in,
  input  logic [1:0]  spres,
  input  logic        spr_en,
  input  logic [15:0] sprdata,
  input  logic [7:0]  attach,
  output logic [7:0]  spr_aen,
  output logic [1:0]  spr_address,
  output logic [15:0] spr_data,
  output logic        shift,
  output logic        pix_valid,
  output logic [2:0]  pix_num,
  output logic [3:0]  pix_color
);

  typedef enum logic [1:0] {
    RES_LO  = 2'd0,
    RES_HI  = 2'd1,
    RES_SHI = 2'd2
  } res_t;

  logic [1:0] phase;
  res_t       mode_q;
  res_t       mode_req;
  res_t       mode_cur;
  logic       shift_next;
  logic       hit;

  // Register write decode: outputs change only on clk7_en so they stay put for a full clk7 period.
  assign hit = reg_wr && (reg_addr[7:5] == SPR_BASE[7:5]);

  always_ff @(posedge clk) begin
    if (reset) begin
      spr_aen     <= 8'd0;
      spr_address <= 2'd0;
      spr_data    <= 16'd0;
    end else if (clk7_en) begin
      if (hit) begin
        spr_aen     <= 8'd1 << reg_addr[4:2];
        spr_address <= reg_addr[1:0];
        spr_data    <= data_in;
      end else begin
        spr_aen <= 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clk7_en) begin
      phase <= 2'd0;
    end else begin
      phase <= phase + 2'd1;
    end
  end

  always_comb begin
    mode_req = RES_LO;
    case (spres)
      2'b10:   mode_req = RES_HI;
`ifdef SPR_SHRES_EN
      2'b11:   mode_req = RES_SHI;
`else
      2'b11:   mode_req = RES_HI;
`endif
      default: mode_req = RES_LO;
    endcase
  end

  // Resolution is only re-sampled at phase 0 so a lores group is never split.
  assign mode_cur = (phase == 2'd0) ? mode_req : mode_q;

  always_comb begin
    shift_next = 1'b0;
    case (mode_cur)
      RES_LO:  shift_next = (phase == 2'd0);
      RES_HI:  shift_next = ~phase[0];
      RES_SHI: shift_next = 1'b1;
      default: shift_next = 1'b0;
    endcase
    shift_next = shift_next & spr_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= RES_LO;
      shift  <= 1'b0;
    end else begin
      mode_q <= mode_cur;
      shift  <= shift_next;
    end
  end

  logic       arb_valid;
  logic [2:0] arb_num;
  logic [3:0] arb_color;
  logic [1:0] d_e;
  logic [1:0] d_o;

  // Walk from the lowest-priority pair upward so pair 0 has the final say.
  always_comb begin
    arb_valid = 1'b0;
    arb_num   = 3'd0;
    arb_color = 4'd0;
    d_e       = 2'd0;
    d_o       = 2'd0;
    for (int p = NSPR / 2 - 1; p >= 0; p--) begin
      d_e = sprdata[4*p +: 2];
      d_o = sprdata[4*p+2 +: 2];
      if (attach[2*p+1]) begin
        if ({d_o, d_e} != 4'd0) begin
          arb_valid = 1'b1;
          arb_num   = 3'(2*p);
          arb_color = {d_o, d_e};
        end
      end else if (d_e != 2'd0) begin
        arb_valid = 1'b1;
        arb_num   = 3'(2*p);
        arb_color = {2'b00, d_e};
      end else if (d_o != 2'd0) begin
        arb_valid = 1'b1;
        arb_num   = 3'(2*p+1);
        arb_color = {2'b00, d_o};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !spr_en || !arb_valid) begin
      pix_valid <= 1'b0;
      pix_num   <= 3'd0;
      pix_color <= 4'd0;
    end else begin
      pix_valid <= 1'b1;
      pix_num   <= arb_num;
      pix_color <= arb_color;
    end
  end

endmodule

// File: tb/tb_denise_sprite_sequencer.sv
// tb/tb_denise_sprite_sequencer.sv - randomized and directed checks of denise_sprite_sequencer against a reference model.
module tb_denise_sprite_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk7_en = 1'b0;
  logic        reg_wr = 1'b0;
  logic [7:0]  reg_addr = 8'd0;
  logic [15:0] data_in = 16'd0;
  logic [1:0]  spres = 2'd0;
  logic        spr_en = 1'b0;
  logic [15:0] sprdata = 16'd0;
  logic [7:0]  attach = 8'd0;
  logic [7:0]  spr_aen;
  logic [1:0]  spr_address;
  logic [15:0] spr_data;
  logic        shift;
  logic        pix_valid;
  logic [2:0]  pix_num;
  logic [3:0]  pix_color;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state
  int          m_phase = 0;
  int          m_rate = 1;
  logic [7:0]  e_aen = 0;
  logic [1:0]  e_addr = 0;
  logic [15:0] e_data = 0;
  logic        e_shift = 0;
  logic        e_valid = 0;
  int          e_num = 0;
  int          e_color = 0;

  denise_sprite_sequencer dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .data_in(data_in), .spres(spres), .spr_en(spr_en),
    .sprdata(sprdata), .attach(attach), .spr_aen(spr_aen),
    .spr_address(spr_address), .spr_data(spr_data), .shift(shift),
    .pix_valid(pix_valid), .pix_num(pix_num), .pix_color(pix_color)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rate_of(input logic [1:0] r);
    if (r == 2'b10) return 2;
`ifdef SPR_SHRES_EN
    if (r == 2'b11) return 4;
`else
    if (r == 2'b11) return 2;
`endif
    return 1;
  endfunction

  task automatic model_pixel();
    int de, dov;
    e_valid = 0; e_num = 0; e_color = 0;
    if (!spr_en) return;
    for (int p = 0; p < 4; p++) begin
      de  = int'(sprdata[4*p +: 2]);
      dov = int'(sprdata[4*p+2 +: 2]);
      if (attach[2*p+1]) begin
        if (dov * 4 + de != 0) begin
          e_valid = 1; e_num = 2*p; e_color = dov * 4 + de; return;
        end
      end else if (de != 0) begin
        e_valid = 1; e_num = 2*p; e_color = de; return;
      end else if (dov != 0) begin
        e_valid = 1; e_num = 2*p + 1; e_color = dov; return;
      end
    end
  endtask

  // One clock: clk7_en follows the bench's cycle counter, model predicts, DUT is compared at negedge.
  task automatic tick();
    int eff;
    clk7_en = (cyc % 4 == 0);
    if (reset) begin
      e_aen = 0; e_addr = 0; e_data = 0; e_shift = 0;
      e_valid = 0; e_num = 0; e_color = 0;
      m_phase = 0; m_rate = 1;
    end else begin
      if (clk7_en) begin
        if (reg_wr && reg_addr >= 8'hA0 && reg_addr <= 8'hBF) begin
          e_aen  = 8'(1 << ((reg_addr - 8'hA0) / 4));
          e_addr = 2'((reg_addr - 8'hA0) % 4);
          e_data = data_in;
        end else begin
          e_aen = 0;
        end
      end
      eff = (m_phase == 0) ? rate_of(spres) : m_rate;
      m_rate = eff;
      e_shift = spr_en && (m_phase % (4 / eff) == 0);
      model_pixel();
      m_phase = clk7_en ? 0 : (m_phase + 1) % 4;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("spr_aen", spr_aen, e_aen);
    check("spr_address", spr_address, e_addr);
    check("spr_data", spr_data, e_data);
    check("shift", shift, e_shift);
    check("pix_valid", pix_valid, e_valid);
    check("pix_num", pix_num, e_num);
    check("pix_color", pix_color, e_color);
  endtask

  task automatic align_clk7();
    while (cyc % 4 != 0) tick();
  endtask

  int nshift;

  initial begin
    @(negedge clk);
    tick(); tick();
    check("reset_aen", spr_aen, 0);
    check("reset_shift", shift, 0);
    check("reset_pix", {pix_valid, pix_num, pix_color}, 0);
    reset = 1'b0;

    // SPR1DATB write: word address 0xA7
    align_clk7();
    reg_wr = 1; reg_addr = 8'hA7; data_in = 16'h1234;
    tick();
    reg_wr = 0;
    check("wr_aen", spr_aen, 8'b0000_0010);
    check("wr_address", spr_address, 3);
    check("wr_data", spr_data, 16'h1234);
    tick(); tick(); tick();
    check("wr_hold_aen", spr_aen, 8'b0000_0010);
    tick();
    check("wr_clear_aen", spr_aen, 0);

    // out of range addresses
    align_clk7();
    reg_wr = 1; reg_addr = 8'h9F; tick();
    check("oor_9f_aen", spr_aen, 0);
    align_clk7();
    reg_addr = 8'hC0; tick();
    check("oor_c0_aen", spr_aen, 0);
    reg_wr = 0;

    // shift rates, counted over the second aligned group
    for (int m = 0; m < 5; m++) begin
      logic [1:0] r;
      int expn;
      r = (m == 4) ? 2'b00 : 2'(m);
      spres = r; spr_en = (m != 4);
      align_clk7();
      for (int i = 0; i < 4; i++) tick();
      nshift = 0;
      for (int i = 0; i < 4; i++) begin tick(); nshift += int'(shift); end
      expn = (m == 4) ? 0 : rate_of(r);
      check("shift_count", nshift, expn);
    end

    // priority
    spr_en = 1; attach = 8'h00;
    sprdata = 16'h0000; sprdata[5:4] = 2'b01; sprdata[11:10] = 2'b11;
    tick();
    check("prio_valid", pix_valid, 1);
    check("prio_num", pix_num, 2);
    check("prio_color", pix_color, 4'b0001);

    // attach
    sprdata = 16'h0000; sprdata[15:14] = 2'b10; sprdata[13:12] = 2'b01;
    attach = 8'h80; tick();
    check("att_num", pix_num, 6);
    check("att_color", pix_color, 4'b1001);
    attach = 8'h00; tick();
    check("noatt_num", pix_num, 6);
    check("noatt_color", pix_color, 4'b0001);

    // reset during write and active pixel
    align_clk7();
    reg_wr = 1; reg_addr = 8'hB2; data_in = 16'hBEEF; reset = 1;
    tick();
    check("rst_aen", spr_aen, 0);
    check("rst_data", spr_data, 0);
    check("rst_pix", {pix_valid, pix_num, pix_color}, 0);
    reg_wr = 0; reset = 0;
    spres = 2'b00; spr_en = 1;
    tick();
    check("rst_phase_shift", shift, 1);
    tick();
    check("rst_phase_shift2", shift, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      reg_wr   = ($urandom_range(0, 2) == 0);
      reg_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'hA0, 8'hBF));
      data_in  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) spres = 2'($urandom);
      spr_en   = ($urandom_range(0, 5) != 0);
      for (int s = 0; s < 8; s++)
        sprdata[2*s +: 2] = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom);
      attach   = 8'($urandom);
      reset    = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
